// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: hazard controller state encodings and register constants.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        HZ_RUN  = 2'd0,
        HZ_HOLD = 2'd1,
        HZ_FRZ  = 2'd2
    } haz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_match_cmp.sv
// Flags when a producer register is sourced by the instruction in ID; r0 never matches.
module reg_match_cmp
    import mips_pipe_pkg::*;
(
    input  logic [4:0] prod_reg,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       reads_rt_id,
    output logic       match
);

    assign match = (prod_reg != REG_ZERO) &&
                   ((prod_reg == rs_id) || (reads_rt_id && (prod_reg == rt_id)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID/EX hazard controller: load-use and branch-operand stalls, memory freezes, branch flush.
//
// state   | meaning
// HZ_RUN  | normal issue; hazards stall in the same cycle
// HZ_HOLD | second bubble owed by a branch that depends on a load
// HZ_FRZ  | data memory not ready; holdPend remembers an owed bubble
module hazard_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memRead_ID_EX,
    input  logic             regWrite_ID_EX,
    input  logic [4:0]       rt_ID_EX,
    input  logic [4:0]       destReg_EX,
    input  logic             memRead_EX_MEM,
    input  logic [4:0]       destReg_EX_MEM,
    input  logic [4:0]       rs_IF_ID,
    input  logic [4:0]       rt_IF_ID,
    input  logic             readsRt_IF_ID,
    input  logic             isBranch_IF_ID,
    input  logic             branchTaken_ID,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             idExWrite,
    output logic             ctrlBubble,
    output logic [1:0]       hazState,
    output logic [CNT_W-1:0] stallCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    haz_state_e       state_q, state_d, eff_state;
    logic             hold_pend_q, hold_pend_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic match_ld, match_ex, match_mem;
    logic load_use, br_load, br_alu, br_mem, any_haz;
    logic pc_we, ifid_we, ifid_fl, idex_we, bubble;

    reg_match_cmp u_cmp_ld (
        .prod_reg    (rt_ID_EX),
        .rs_id       (rs_IF_ID),
        .rt_id       (rt_IF_ID),
        .reads_rt_id (readsRt_IF_ID),
        .match       (match_ld)
    );

    reg_match_cmp u_cmp_ex (
        .prod_reg    (destReg_EX),
        .rs_id       (rs_IF_ID),
        .rt_id       (rt_IF_ID),
        .reads_rt_id (readsRt_IF_ID),
        .match       (match_ex)
    );

    reg_match_cmp u_cmp_mem (
        .prod_reg    (destReg_EX_MEM),
        .rs_id       (rs_IF_ID),
        .rt_id       (rt_IF_ID),
        .reads_rt_id (readsRt_IF_ID),
        .match       (match_mem)
    );

    assign load_use = memRead_ID_EX && match_ld;
    assign br_load  = isBranch_IF_ID && memRead_ID_EX && match_ld;
    assign br_alu   = isBranch_IF_ID && regWrite_ID_EX && !memRead_ID_EX && match_ex;
    assign br_mem   = isBranch_IF_ID && memRead_EX_MEM && match_mem;
    assign any_haz  = load_use || br_load || br_alu || br_mem;

    always_comb begin
        state_d     = state_q;
        hold_pend_d = hold_pend_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_fl     = 1'b0;
        idex_we     = 1'b0;
        bubble      = 1'b0;

        // Leaving a freeze behaves exactly like the state it interrupted.
        eff_state = state_q;
        if (state_q == HZ_FRZ && memReady) begin
            eff_state = hold_pend_q ? HZ_HOLD : HZ_RUN;
        end

        case (eff_state)
            HZ_RUN: begin
                if (!memReady) begin
                    state_d     = HZ_FRZ;
                    hold_pend_d = 1'b0;
                end else if (any_haz) begin
                    idex_we = 1'b1;
                    bubble  = 1'b1;
                    state_d = br_load ? HZ_HOLD : HZ_RUN;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                    ifid_fl = branchTaken_ID;
                    state_d = HZ_RUN;
                end
            end
            HZ_HOLD: begin
                if (!memReady) begin
                    state_d     = HZ_FRZ;
                    hold_pend_d = 1'b1;
                end else begin
                    idex_we = 1'b1;
                    bubble  = 1'b1;
                    state_d = HZ_RUN;
                end
            end
            HZ_FRZ: state_d = HZ_FRZ;
            default: begin
                state_d     = HZ_RUN;
                hold_pend_d = 1'b0;
            end
        endcase

        if (!reset) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            ifid_fl = 1'b0;
            idex_we = 1'b0;
            bubble  = 1'b0;
        end

        stall_count_d = stall_count_q;
        if (bubble && stall_count_q != CNT_MAX) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= HZ_RUN;
            hold_pend_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_pend_q   <= hold_pend_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pcWrite    = pc_we;
    assign ifIdWrite  = ifid_we;
    assign ifIdFlush  = ifid_fl;
    assign idExWrite  = idex_we;
    assign ctrlBubble = bubble;
    assign hazState   = state_q;
    assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed pipeline scenarios then random traffic.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;
    localparam int CNT_SAT = 15;

    logic clk = 1'b0;
    logic reset, memRead_ID_EX, regWrite_ID_EX, memRead_EX_MEM;
    logic readsRt_IF_ID, isBranch_IF_ID, branchTaken_ID, memReady;
    logic [4:0] rt_ID_EX, destReg_EX, destReg_EX_MEM, rs_IF_ID, rt_IF_ID;
    logic pcWrite, ifIdWrite, ifIdFlush, idExWrite, ctrlBubble;
    logic [1:0] hazState;
    logic [CNT_W-1:0] stallCount;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .memRead_ID_EX  (memRead_ID_EX),
        .regWrite_ID_EX (regWrite_ID_EX),
        .rt_ID_EX       (rt_ID_EX),
        .destReg_EX     (destReg_EX),
        .memRead_EX_MEM (memRead_EX_MEM),
        .destReg_EX_MEM (destReg_EX_MEM),
        .rs_IF_ID       (rs_IF_ID),
        .rt_IF_ID       (rt_IF_ID),
        .readsRt_IF_ID  (readsRt_IF_ID),
        .isBranch_IF_ID (isBranch_IF_ID),
        .branchTaken_ID (branchTaken_ID),
        .memReady       (memReady),
        .pcWrite        (pcWrite),
        .ifIdWrite      (ifIdWrite),
        .ifIdFlush      (ifIdFlush),
        .idExWrite      (idExWrite),
        .ctrlBubble     (ctrlBubble),
        .hazState       (hazState),
        .stallCount     (stallCount)
    );

    typedef struct packed {
        logic [4:0] ctl;     // {pcWrite, ifIdWrite, ifIdFlush, idExWrite, ctrlBubble}
        logic [1:0] st;
        logic [3:0] cnt;
        logic       chk_st;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: bubbles still owed, whether memory is holding us, bubble tally.
    int owed = 0;
    bit frozen = 0;
    int bubbles = 0;
    bit model_known = 0;

    function automatic bit src_match(input logic [4:0] r);
        return (r != 0) && (r == rs_IF_ID || (readsRt_IF_ID && r == rt_IF_ID));
    endfunction

    task automatic cycle();
        exp_t e;
        bit ld_use, br_ld, br_al, br_mm, stall;
        ld_use = memRead_ID_EX && src_match(rt_ID_EX);
        br_ld  = isBranch_IF_ID && ld_use;
        br_al  = isBranch_IF_ID && regWrite_ID_EX && !memRead_ID_EX && src_match(destReg_EX);
        br_mm  = isBranch_IF_ID && memRead_EX_MEM && src_match(destReg_EX_MEM);
        e.chk_st = model_known;
        e.st  = frozen ? 2'd2 : (owed > 0 ? 2'd1 : 2'd0);
        e.cnt = 4'(bubbles);
        stall = 0;
        if (!reset || !memReady) e.ctl = 5'b00000;
        else if (owed > 0 || ld_use || br_al || br_mm) begin
            e.ctl = 5'b00011;
            stall = 1;
        end else e.ctl = {2'b11, branchTaken_ID, 2'b10};
        exp_q.push_back(e);

        if (!reset) begin
            owed = 0; frozen = 0; bubbles = 0; model_known = 1;
        end else if (!memReady) begin
            frozen = 1;
        end else begin
            frozen = 0;
            if (owed > 0) owed = owed - 1;
            else if (stall) owed = br_ld ? 1 : 0;
            if (stall && bubbles < CNT_SAT) bubbles = bubbles + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        reset = 1; memReady = 1;
        memRead_ID_EX = 0; regWrite_ID_EX = 0; memRead_EX_MEM = 0;
        readsRt_IF_ID = 0; isBranch_IF_ID = 0; branchTaken_ID = 0;
        rt_ID_EX = 0; destReg_EX = 0; destReg_EX_MEM = 0; rs_IF_ID = 0; rt_IF_ID = 0;
    endtask

    task automatic branch_after_load();
        clear_in();
        isBranch_IF_ID = 1; memRead_ID_EX = 1; rt_ID_EX = 9; rt_IF_ID = 9;
        readsRt_IF_ID = 1; branchTaken_ID = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({pcWrite, ifIdWrite, ifIdFlush, idExWrite, ctrlBubble} === e.ctl) n_pass++;
            else $display("FAIL ctl t=%0t got %b want %b", $time,
                          {pcWrite, ifIdWrite, ifIdFlush, idExWrite, ctrlBubble}, e.ctl);
            if (e.chk_st) begin
                n_checks++;
                if (hazState === e.st) n_pass++;
                else $display("FAIL hazState t=%0t got %0d want %0d", $time, hazState, e.st);
                n_checks++;
                if (stallCount === e.cnt) n_pass++;
                else $display("FAIL stallCount t=%0t got %0d want %0d", $time, stallCount, e.cnt);
            end
        end
    end

    initial begin
        clear_in();
        reset = 0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset = 1;
        cycle();

        // load-use: one bubble then normal
        memRead_ID_EX = 1; rt_ID_EX = 8; rs_IF_ID = 8;
        cycle();
        clear_in(); cycle();

        // r0 never hazards
        memRead_ID_EX = 1; rt_ID_EX = 0; rs_IF_ID = 0;
        cycle(); cycle();

        // taken branch after load: two bubbles, flush only afterwards
        branch_after_load();
        cycle(); cycle();
        memRead_ID_EX = 0;
        cycle();
        clear_in(); cycle();

        // freeze landing in HOLD defers, not drops, the second bubble
        branch_after_load();
        cycle();
        memReady = 0;
        cycle(); cycle(); cycle();
        memReady = 1;
        cycle();
        clear_in(); cycle();

        // branch after ALU producer
        regWrite_ID_EX = 1; destReg_EX = 5; rs_IF_ID = 5; isBranch_IF_ID = 1;
        cycle();
        clear_in(); cycle();

        // saturation then a one-edge reset
        memRead_ID_EX = 1; rt_ID_EX = 8; rs_IF_ID = 8;
        for (int i = 0; i < 20; i++) cycle();
        clear_in();
        reset = 0;
        cycle();
        reset = 1;
        cycle(); cycle();

        // random traffic on a small register space to make collisions frequent
        for (int i = 0; i < 2000; i++) begin
            reset          = ($urandom_range(0, 99) >= 2);
            memReady       = ($urandom_range(0, 99) >= 15);
            memRead_ID_EX  = 1'($urandom);
            regWrite_ID_EX = 1'($urandom);
            memRead_EX_MEM = 1'($urandom);
            readsRt_IF_ID  = 1'($urandom);
            isBranch_IF_ID = 1'($urandom);
            branchTaken_ID = 1'($urandom);
            rt_ID_EX       = 5'($urandom_range(0, 3));
            destReg_EX     = 5'($urandom_range(0, 3));
            destReg_EX_MEM = 5'($urandom_range(0, 3));
            rs_IF_ID       = 5'($urandom_range(0, 3));
            rt_IF_ID       = 5'($urandom_range(0, 3));
            cycle();
        end

        clear_in();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Consumer-side controller for the ID/EX pipeline register in the pipelined MIPS.
- Reads the control and register fields latched in ID/EX and EX/MEM, and compares them with the instruction currently in IF/ID.
- Generates the write-enable (`idExWrite`) and control-bubble select for ID/EX, plus PC and IF/ID write enables and the IF/ID flush.
- Sequences multi-cycle stalls, data-memory freezes and taken-branch flushes, and keeps a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall-cycle counter `stallCount`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- memRead_ID_EX  in  1  instruction in EX is a load.
- regWrite_ID_EX  in  1  instruction in EX writes a register.
- rt_ID_EX  in  5  rt field in EX (the load destination).
- destReg_EX  in  5  EX destination after the regDest mux.
- memRead_EX_MEM  in  1  instruction in MEM is a load.
- destReg_EX_MEM  in  5  MEM destination register.
- rs_IF_ID  in  5  rs of the instruction in ID.
- rt_IF_ID  in  5  rt of the instruction in ID.
- readsRt_IF_ID  in  1  the instruction in ID sources rt.
- isBranch_IF_ID  in  1  the instruction in ID is a branch resolved in ID.
- branchTaken_ID  in  1  branch resolved as taken this cycle.
- memReady  in  1  data memory ready; 0 freezes the pipeline.
- pcWrite  out  1  PC write enable.
- ifIdWrite  out  1  IF/ID write enable.
- ifIdFlush  out  1  clear IF/ID, one cycle.
- idExWrite  out  1  ID/EX write enable (drives ID/EX regWr).
- ctrlBubble  out  1  zero the control fields entering ID/EX.
- hazState  out  2  current FSM state.
- stallCount  out  CNT_W  bubbles inserted, saturating.

Behaviour:
Hazard terms (combinational):
- `match(r)` = `r != 0 && (r == rs_IF_ID || (readsRt_IF_ID && r == rt_IF_ID))`. Register r0 never causes a hazard.
- `loadUse` = `memRead_ID_EX && match(rt_ID_EX)`; needs 1 bubble.
- `brLoad` = `isBranch_IF_ID && memRead_ID_EX && match(rt_ID_EX)`; needs 2 bubbles.
- `brAlu` = `isBranch_IF_ID && regWrite_ID_EX && !memRead_ID_EX && match(destReg_EX)`; needs 1 bubble.
- `brMem` = `isBranch_IF_ID && memRead_EX_MEM && match(destReg_EX_MEM)`; needs 1 bubble.

Output modes:
- STALL: `pcWrite`=0, `ifIdWrite`=0, `idExWrite`=1, `ctrlBubble`=1, `ifIdFlush`=0.
- FREEZE: all five outputs = 0.
- NORMAL: `pcWrite`=1, `ifIdWrite`=1, `idExWrite`=1, `ctrlBubble`=0, `ifIdFlush` = `branchTaken_ID`.

FSM states (`hazState`): RUN=0, HOLD=1, FRZ=2. A pending bit `holdPend` is also kept.
- RUN:
  - `memReady`=0 → FREEZE mode; next state FRZ with `holdPend`=0.
  - Otherwise, if any hazard term is true → STALL mode (same cycle, Mealy).
    - If `brLoad` → next state HOLD.
    - Otherwise → next state RUN.
  - Otherwise → NORMAL mode; stay in RUN.
- HOLD:
  - `memReady`=0 → FREEZE mode; next state FRZ with `holdPend`=1.
  - Otherwise → STALL mode unconditionally, then RUN.
- FRZ:
  - FREEZE mode while `memReady`=0.
  - When `memReady`=1: outputs are those of the return state evaluated this cycle.
    - If `holdPend`=1, the return state is HOLD; otherwise RUN.
    - The next state is chosen by that state's rules.

Timing and boundary rules:
- Freeze has priority over stall; stall has priority over flush.
- A taken branch whose operands are still stalled is never flushed.
- Latency: hazard to stall is 0 cycles. `brLoad` produces exactly 2 consecutive bubble cycles; every other hazard produces 1.
- A freeze in the middle of HOLD defers the second bubble; it is neither lost nor duplicated.

Stall counter:
- `stallCount` += 1 on each rising edge where `ctrlBubble`=1.
- Saturates at 2^CNT_W−1 and does not wrap.

Reset (`reset`=0 at an edge):
- State → RUN, `holdPend` → 0, `stallCount` → 0.
- While `reset`=0, all five enables/flush outputs are forced to 0.
- The first cycle after release behaves as RUN.
- Reset in the middle of HOLD or FRZ abandons the pending bubble.

Decomposition:
- Shared package `mips_pipe_pkg` holds:
  - hazard state encodings `HZ_RUN`, `HZ_HOLD`, `HZ_FRZ`;
  - constant `REG_ZERO` = 5'd0.
- One sub-module, `reg_match_cmp`: a 5-bit comparator implementing `match(r)`. It is instantiated 3 times, for `rt_ID_EX`, `destReg_EX` and `destReg_EX_MEM`.

Test Plan:
- Load-use: `memRead_ID_EX`=1, `rt_ID_EX`=8, `rs_IF_ID`=8 → 1 cycle with `pcWrite`=0, `ctrlBubble`=1, then NORMAL; `stallCount`=1.
- r0 immunity: load with `rt_ID_EX`=0, `rs_IF_ID`=0 → no stall; `stallCount` stays 0.
- Branch after load: `isBranch_IF_ID`=1, `memRead_ID_EX`=1, `rt_ID_EX`=9, `rt_IF_ID`=9, `readsRt_IF_ID`=1, `branchTaken_ID`=1 → `hazState` sequence RUN, HOLD, RUN; 2 bubbles; `ifIdFlush`=0 during both bubbles and 1 in the following NORMAL cycle.
- Freeze in HOLD: as the branch-after-load case, but `memReady`=0 for 3 cycles starting in HOLD → all enables 0 for 3 cycles, then exactly 1 bubble; total `stallCount`=2.
- Branch after ALU: `regWrite_ID_EX`=1, `destReg_EX`=5, `rs_IF_ID`=5, `isBranch_IF_ID`=1 → exactly 1 bubble.
- Saturation and reset: with CNT_W=4, force 20 bubbles → `stallCount`=15. Then hold `reset`=0 for 1 edge → `stallCount`=0, `hazState`=RUN.
